// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access stage.
// Holds the FSM state encoding and the default abort timeout.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 16;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Timeout counter for the memory access stage.
// Ports: clk, reset (async, active-low), clear, enable; tc = terminal count.
module mem_timeout_cnt #(
  parameter int W     = 16,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/mem_access.sv
// MEM stage: issues one load/store, waits for mem_ack or aborts on timeout.
// Ports: op_* from EX/MEM, mem_* to memory, main_mem_dat/stall/done/err out.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic              op_read,
  input  logic              op_write,
  input  logic [DATA_W-1:0] op_adr,
  input  logic [DATA_W-1:0] op_wdat,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdat,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdat,
  output logic [DATA_W-1:0] main_mem_dat,
  output logic              stall,
  output logic              done,
  output logic              err
);

  state_t state;
  state_t next;

  logic mem_op;
  logic issue;
  logic in_busy;
  logic tc;

  assign mem_op  = op_valid & (op_read | op_write) & ~flush;
  assign issue   = (state == IDLE) & mem_op;
  assign in_busy = (state == BUSY);

  mem_timeout_cnt #(
    .W     (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (issue),
    .enable (in_busy & ~mem_ack),
    .tc     (tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // ack beats timeout when both land in the terminal cycle
  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (mem_op) next = BUSY;
      BUSY: begin
        if (mem_ack) begin
          next = DONE;
        end else if (tc) begin
          next = ERR;
        end
      end
      DONE: next = IDLE;
      ERR:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  // a simultaneous read+write is issued as a write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_adr      <= '0;
      mem_wdat     <= '0;
      mem_we       <= 1'b0;
      main_mem_dat <= '0;
    end else begin
      if (issue) begin
        mem_adr  <= op_adr;
        mem_wdat <= op_wdat;
        mem_we   <= op_write;
      end
      if (in_busy & mem_ack & ~mem_we) begin
        main_mem_dat <= mem_rdat;
      end
    end
  end

  // derived from state so async reset drops them at once
  assign mem_req = in_busy;
  assign done    = (state == DONE);
  assign err     = (state == ERR);
  assign stall   = in_busy | issue;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access with a transaction-level model.
// Two instances (long and short timeout) share stimulus; sel picks one.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid, op_read, op_write, flush, mem_ack;
  logic [15:0] op_adr, op_wdat, mem_rdat;

  logic        a_req, a_we, a_stall, a_done, a_err;
  logic [15:0] a_adr, a_wdat, a_rd;
  logic        b_req, b_we, b_stall, b_done, b_err;
  logic [15:0] b_adr, b_wdat, b_rd;

  logic        mem_req, mem_we, stall, done, err;
  logic [15:0] mem_adr, mem_wdat, main_mem_dat;

  bit          sel = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          tmo;
  logic [15:0] exp_rd;

  always #5 clk = ~clk;

  mem_access #(.DATA_W(16), .TIMEOUT(16)) u_a (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_read(op_read), .op_write(op_write),
    .op_adr(op_adr), .op_wdat(op_wdat), .flush(flush),
    .mem_req(a_req), .mem_we(a_we), .mem_adr(a_adr), .mem_wdat(a_wdat),
    .mem_ack(mem_ack), .mem_rdat(mem_rdat), .main_mem_dat(a_rd),
    .stall(a_stall), .done(a_done), .err(a_err)
  );

  mem_access #(.DATA_W(16), .TIMEOUT(4)) u_b (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_read(op_read), .op_write(op_write),
    .op_adr(op_adr), .op_wdat(op_wdat), .flush(flush),
    .mem_req(b_req), .mem_we(b_we), .mem_adr(b_adr), .mem_wdat(b_wdat),
    .mem_ack(mem_ack), .mem_rdat(mem_rdat), .main_mem_dat(b_rd),
    .stall(b_stall), .done(b_done), .err(b_err)
  );

  assign mem_req      = sel ? b_req   : a_req;
  assign mem_we       = sel ? b_we    : a_we;
  assign mem_adr      = sel ? b_adr   : a_adr;
  assign mem_wdat     = sel ? b_wdat  : a_wdat;
  assign main_mem_dat = sel ? b_rd    : a_rd;
  assign stall        = sel ? b_stall : a_stall;
  assign done         = sel ? b_done  : a_done;
  assign err          = sel ? b_err   : a_err;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 16'(mem_req), 16'd0);
    chk({tag, "_we"}, 16'(mem_we), 16'd0);
    chk({tag, "_adr"}, mem_adr, 16'd0);
    chk({tag, "_wdat"}, mem_wdat, 16'd0);
    chk({tag, "_rd"}, main_mem_dat, 16'd0);
    chk({tag, "_done"}, 16'(done), 16'd0);
    chk({tag, "_err"}, 16'(err), 16'd0);
    chk({tag, "_stall"}, 16'(stall), 16'd0);
  endtask

  // One transaction. Model: ack on BUSY cycle k (1..tmo) completes,
  // otherwise tmo BUSY cycles then an error pulse.
  task automatic run_op(input bit rd, input bit wr,
                        input logic [15:0] adr, input logic [15:0] wd,
                        input int ack_at, input logic [15:0] rdat,
                        input bit fl_busy);
    bit acked;
    int busy_n;
    acked  = (ack_at >= 1) && (ack_at <= tmo);
    busy_n = acked ? ack_at : tmo;
    op_valid = 1'b1;
    op_read  = rd;
    op_write = wr;
    op_adr   = adr;
    op_wdat  = wd;
    flush    = 1'b0;
    #1;
    chk("issue_stall", 16'(stall), 16'd1);
    chk("issue_req", 16'(mem_req), 16'd0);
    tick();
    for (int k = 1; k <= busy_n; k++) begin
      flush    = fl_busy;
      op_adr   = 16'($urandom);
      op_wdat  = 16'($urandom);
      mem_rdat = 16'($urandom);
      #1;
      chk("busy_req", 16'(mem_req), 16'd1);
      chk("busy_stall", 16'(stall), 16'd1);
      chk("busy_adr", mem_adr, adr);
      chk("busy_we", 16'(mem_we), 16'(wr));
      chk("busy_wdat", mem_wdat, wd);
      chk("busy_done", 16'(done), 16'd0);
      chk("busy_err", 16'(err), 16'd0);
      if (acked && k == ack_at) begin
        mem_ack  = 1'b1;
        mem_rdat = rdat;
      end
      tick();
      mem_ack = 1'b0;
    end
    if (acked && !wr) exp_rd = rdat;
    #1;
    chk("end_done", 16'(done), 16'(acked));
    chk("end_err", 16'(err), 16'(!acked));
    chk("end_req", 16'(mem_req), 16'd0);
    chk("end_stall", 16'(stall), 16'd0);
    chk("end_rdat", main_mem_dat, exp_rd);
    tick();
    op_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk("post_req", 16'(mem_req), 16'd0);
    chk("post_done", 16'(done), 16'd0);
    chk("post_err", 16'(err), 16'd0);
    tick();
  endtask

  task automatic rand_ops(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      t = $urandom_range(0, 2);
      run_op(t != 1, t != 0, 16'($urandom), 16'($urandom),
             $urandom_range(0, tmo + 1), 16'($urandom),
             1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    op_valid = 1'b0; op_read = 1'b0; op_write = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; op_adr = '0; op_wdat = '0; mem_rdat = '0;
    tmo = 16;
    exp_rd = '0;
    #12;
    chk_zero("rst");
    reset = 1'b1;
    tick();

    run_op(1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'hBEEF, 1'b0);
    run_op(1'b0, 1'b1, 16'h0010, 16'h1234, 5, 16'h5A5A, 1'b0);
    run_op(1'b1, 1'b1, 16'h0022, 16'hCAFE, 2, 16'h7777, 1'b0);
    run_op(1'b1, 1'b0, 16'h0030, 16'h0000, 3, 16'h3C3C, 1'b1);

    op_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; flush = 1'b1;
    #1;
    chk("flush_stall", 16'(stall), 16'd0);
    tick();
    chk("flush_req", 16'(mem_req), 16'd0);
    flush = 1'b0; op_read = 1'b0;
    #1;
    chk("nonmem_stall", 16'(stall), 16'd0);
    tick();
    chk("nonmem_req", 16'(mem_req), 16'd0);
    chk("nonmem_done", 16'(done), 16'd0);
    op_valid = 1'b0;
    mem_ack = 1'b1; mem_rdat = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("idle_ack_rd", main_mem_dat, exp_rd);
    chk("idle_ack_done", 16'(done), 16'd0);
    tick();

    rand_ops(25);

    reset = 1'b0;
    sel = 1'b1;
    tmo = 4;
    exp_rd = '0;
    #1;
    chk_zero("rst_b");
    #2;
    reset = 1'b1;
    tick();

    run_op(1'b1, 1'b0, 16'h0050, 16'h0000, 0, 16'h1111, 1'b0);
    run_op(1'b1, 1'b0, 16'h0060, 16'h0000, 4, 16'hA5A5, 1'b0);
    rand_ops(25);

    op_valid = 1'b1; op_read = 1'b1; op_write = 1'b0;
    op_adr = 16'h0070; flush = 1'b0;
    tick();
    tick();
    #1;
    chk("mid_req", 16'(mem_req), 16'd1);
    op_valid = 1'b0; op_read = 1'b0;
    reset = 1'b0;
    #1;
    exp_rd = '0;
    chk_zero("mid_rst");
    #2;
    reset = 1'b1;
    tick();
    run_op(1'b1, 1'b0, 16'h0080, 16'h0000, 2, 16'h4242, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
